// File: rtl/sync_fifo_drain.sv
// Burst drain engine: pulls a requested number of words from a synchronous FIFO
// and presents them on a valid/ready stream through a 2-entry skid buffer.
module sync_fifo_drain #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int PTR_WIDTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [PTR_WIDTH:0]   burst_len_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 fifo_rd_en_o,
    input  logic [WIDTH-1:0]     fifo_rdata_i,
    input  logic                 fifo_empty_i,
    input  logic                 fifo_rd_error_i,
    output logic                 m_valid_o,
    output logic [WIDTH-1:0]     m_data_o,
    input  logic                 m_ready_i,
    output logic [PTR_WIDTH:0]   rd_count_o,
    output logic                 err_o
);

    localparam int CW = PTR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_W = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t          state_r;
    logic [CW-1:0]   len_r;
    logic [CW-1:0]   issued_r;
    logic [CW-1:0]   rd_count_r;
    logic [1:0]      occ_r;
    logic            inflight_r;
    logic [WIDTH-1:0] head_r;
    logic [WIDTH-1:0] tail_r;
    logic            err_r;
    logic            busy_r;
    logic            done_r;

    logic            pop_s;
    logic [2:0]      credit_s;
    logic            rd_en_s;
    logic [WIDTH-1:0] head_s;
    logic [WIDTH-1:0] tail_s;
    logic [1:0]      occ_s;

    // Credit counts words already buffered or on their way, less the one leaving this cycle.
    always_comb begin
        pop_s    = (occ_r != 2'd0) && m_ready_i;
        credit_s = {1'b0, occ_r} + {2'b00, inflight_r} - {2'b00, pop_s};
        rd_en_s  = (state_r == ST_DRAIN) && !fifo_empty_i &&
                   (issued_r < len_r) && (credit_s < 3'd2);
    end

    // Next contents of the two-entry buffer: pop shifts tail to head, arriving word fills the first free slot.
    always_comb begin
        head_s = head_r;
        tail_s = tail_r;
        occ_s  = occ_r;
        case ({pop_s, inflight_r})
            2'b01: begin
                if (occ_r == 2'd0) begin
                    head_s = fifo_rdata_i;
                end else begin
                    tail_s = fifo_rdata_i;
                end
                occ_s = occ_r + 2'd1;
            end
            2'b10: begin
                head_s = tail_r;
                occ_s  = occ_r - 2'd1;
            end
            2'b11: begin
                if (occ_r == 2'd1) begin
                    head_s = fifo_rdata_i;
                end else begin
                    head_s = tail_r;
                    tail_s = fifo_rdata_i;
                end
            end
            default: begin
                occ_s = occ_r;
            end
        endcase
    end

    // Control FSM together with the datapath registers it owns.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r    <= ST_IDLE;
            len_r      <= {CW{1'b0}};
            issued_r   <= {CW{1'b0}};
            rd_count_r <= {CW{1'b0}};
            occ_r      <= 2'd0;
            inflight_r <= 1'b0;
            head_r     <= {WIDTH{1'b0}};
            tail_r     <= {WIDTH{1'b0}};
            err_r      <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            head_r     <= head_s;
            tail_r     <= tail_s;
            occ_r      <= occ_s;
            inflight_r <= rd_en_s;

            if (fifo_rd_error_i) begin
                err_r <= 1'b1;
            end else if ((state_r == ST_IDLE) && start_i) begin
                err_r <= 1'b0;
            end else begin
                err_r <= err_r;
            end

            if ((state_r == ST_IDLE) && start_i) begin
                rd_count_r <= {CW{1'b0}};
            end else if (pop_s && (rd_count_r < len_r)) begin
                rd_count_r <= rd_count_r + CW'(1);
            end else begin
                rd_count_r <= rd_count_r;
            end

            if (state_r == ST_IDLE) begin
                issued_r <= {CW{1'b0}};
            end else if (rd_en_s) begin
                issued_r <= issued_r + CW'(1);
            end else begin
                issued_r <= issued_r;
            end

            case (state_r)
                ST_IDLE: begin
                    if (start_i) begin
                        len_r  <= (burst_len_i > DEPTH_W) ? DEPTH_W : burst_len_i;
                        busy_r <= 1'b1;
                        if (burst_len_i != {CW{1'b0}}) begin
                            state_r <= ST_DRAIN;
                            done_r  <= 1'b0;
                        end else begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end
                    end else begin
                        busy_r <= 1'b0;
                        done_r <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    busy_r <= 1'b1;
                    done_r <= 1'b0;
                    if (issued_r == len_r) begin
                        state_r <= ST_FLUSH;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_FLUSH: begin
                    busy_r <= 1'b1;
                    if ((occ_r == 2'd0) && !inflight_r) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= ST_FLUSH;
                        done_r  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o       = busy_r;
    assign done_o       = done_r;
    assign fifo_rd_en_o = rd_en_s;
    assign m_valid_o    = (occ_r != 2'd0);
    assign m_data_o     = head_r;
    assign rd_count_o   = rd_count_r;
    assign err_o        = err_r;

endmodule

// File: tb/tb_sync_fifo_drain.sv
// Directed bench for sync_fifo_drain with a behavioural FIFO and a stream monitor.
module tb_sync_fifo_drain;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [4:0] burst_len = 5'd0;
    logic       busy, done, rd_en, m_valid, m_ready, rd_error, fifo_empty, err;
    logic [7:0] m_data, rdata;
    logic [4:0] rd_count;

    int checks = 0;
    int passes = 0;

    logic [7:0] mem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int seq = 0;

    int hs_n = 0, rd_n = 0, done_n = 0, cyc = 0, done_cyc = 0;
    int viol_empty = 0, viol_stable = 0, viol_buf = 0, outst = 0;
    logic [7:0] got [0:255];
    int hs_cyc [0:255];
    int rd_cyc [0:255];
    logic prev_v = 1'b0, prev_r = 1'b0;
    logic [7:0] prev_d = 8'd0;

    sync_fifo_drain #(.WIDTH(8), .DEPTH(16), .PTR_WIDTH(4)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .burst_len_i(burst_len),
        .busy_o(busy), .done_o(done), .fifo_rd_en_o(rd_en), .fifo_rdata_i(rdata),
        .fifo_empty_i(fifo_empty), .fifo_rd_error_i(rd_error), .m_valid_o(m_valid),
        .m_data_o(m_data), .m_ready_i(m_ready), .rd_count_o(rd_count), .err_o(err)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_en && !fifo_empty) begin
            rdata  <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 1;
        end
    end

    always @(negedge clk) begin
        if (rd_en && fifo_empty) viol_empty <= viol_empty + 1;
        if (rd_en && !fifo_empty) begin
            rd_cyc[rd_n] <= cyc;
            rd_n <= rd_n + 1;
        end
        if (m_valid && m_ready) begin
            got[hs_n]    <= m_data;
            hs_cyc[hs_n] <= cyc;
            hs_n <= hs_n + 1;
        end
        if (done) begin
            done_n   <= done_n + 1;
            done_cyc <= cyc;
        end
        if (!rst && prev_v && !prev_r && (!m_valid || m_data != prev_d))
            viol_stable <= viol_stable + 1;
        if (rst) begin
            outst <= 0;
        end else begin
            outst <= outst + int'(rd_en && !fifo_empty) - int'(m_valid && m_ready);
            if (outst + int'(rd_en && !fifo_empty) - int'(m_valid && m_ready) > 2)
                viol_buf <= viol_buf + 1;
        end
        prev_v <= m_valid && !rst;
        prev_r <= m_ready;
        prev_d <= m_data;
    end

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr] = 8'(seq * 37 + 11);
            wr_ptr = wr_ptr + 1;
            seq = seq + 1;
        end
    endtask

    task automatic start_burst(input logic [4:0] len);
        @(posedge clk); #1;
        start = 1'b1;
        burst_len = len;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_hs(input int target);
        int k;
        k = 0;
        while (hs_n < target && k < 200) begin
            @(posedge clk);
            k++;
        end
        #1;
    endtask

    task automatic wait_done(input int base);
        int k;
        k = 0;
        while (done_n == base && k < 300) begin
            @(posedge clk);
            k++;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_data(input string name, input int hs0, input int rp, input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++)
            if (got[hs0 + i] !== mem[rp + i]) bad++;
        checks++;
        if (bad != 0) $display("FAIL %s: %0d words wrong, required 0", name, bad);
        else passes++;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy); else passes++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b required 0", done); else passes++;
        checks++; if (rd_en !== 1'b0) $display("FAIL reset_rd_en: got %b required 0", rd_en); else passes++;
        checks++; if (m_valid !== 1'b0) $display("FAIL reset_valid: got %b required 0", m_valid); else passes++;
        checks++; if (m_data !== 8'd0) $display("FAIL reset_data: got %0d required 0", m_data); else passes++;
        checks++; if (rd_count !== 5'd0) $display("FAIL reset_count: got %0d required 0", rd_count); else passes++;
        checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b required 0", err); else passes++;
        rst = 1'b0;
    endtask

    task automatic test_full_burst;
        int hs0, rd0, d0, rp;
        push_words(16);
        hs0 = hs_n; rd0 = rd_n; d0 = done_n; rp = rd_ptr;
        start_burst(5'd16);
        wait_done(d0);
        checks++; if (hs_n - hs0 != 16) $display("FAIL full_count: got %0d required 16", hs_n - hs0); else passes++;
        check_data("full_order", hs0, rp, 16);
        checks++; if (hs_cyc[hs0] - rd_cyc[rd0] != 2)
            $display("FAIL full_latency: got %0d required 2", hs_cyc[hs0] - rd_cyc[rd0]); else passes++;
        checks++; if (hs_cyc[hs0 + 15] - hs_cyc[hs0] != 15)
            $display("FAIL full_rate: got %0d required 15", hs_cyc[hs0 + 15] - hs_cyc[hs0]); else passes++;
        checks++; if (done_n - d0 != 1) $display("FAIL full_done: got %0d required 1", done_n - d0); else passes++;
        checks++; if (rd_count !== 5'd16) $display("FAIL full_rd_count: got %0d required 16", rd_count); else passes++;
        checks++; if (err !== 1'b0) $display("FAIL full_err: got %b required 0", err); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL full_busy: got %b required 0", busy); else passes++;
    endtask

    task automatic test_backpressure;
        int hs0, d0, rp;
        push_words(12);
        hs0 = hs_n; d0 = done_n; rp = rd_ptr;
        start_burst(5'd12);
        wait_hs(hs0 + 3);
        m_ready = 1'b0;
        start = 1'b1; burst_len = 5'd2;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (rd_en !== 1'b0) $display("FAIL bp_rd_en: got %b required 0", rd_en); else passes++;
        checks++; if (m_valid !== 1'b1) $display("FAIL bp_valid: got %b required 1", m_valid); else passes++;
        @(posedge clk); #1;
        m_ready = 1'b1;
        wait_done(d0);
        checks++; if (hs_n - hs0 != 12) $display("FAIL bp_count: got %0d required 12", hs_n - hs0); else passes++;
        check_data("bp_order", hs0, rp, 12);
        checks++; if (viol_buf != 0) $display("FAIL bp_buffered: got %0d overfills required 0", viol_buf); else passes++;
        checks++; if (viol_stable != 0) $display("FAIL bp_stable: got %0d changes required 0", viol_stable); else passes++;
        checks++; if (rd_count !== 5'd12) $display("FAIL bp_rd_count: got %0d required 12", rd_count); else passes++;
    endtask

    task automatic test_underrun;
        int hs0, d0, rp;
        push_words(3);
        hs0 = hs_n; d0 = done_n; rp = rd_ptr;
        start_burst(5'd8);
        wait_hs(hs0 + 3);
        repeat (10) @(posedge clk);
        #1;
        checks++; if (rd_en !== 1'b0) $display("FAIL ur_rd_en: got %b required 0", rd_en); else passes++;
        checks++; if (busy !== 1'b1) $display("FAIL ur_busy: got %b required 1", busy); else passes++;
        push_words(5);
        wait_done(d0);
        checks++; if (hs_n - hs0 != 8) $display("FAIL ur_count: got %0d required 8", hs_n - hs0); else passes++;
        check_data("ur_order", hs0, rp, 8);
        checks++; if (viol_empty != 0) $display("FAIL ur_read_empty: got %0d required 0", viol_empty); else passes++;
        checks++; if (err !== 1'b0) $display("FAIL ur_err: got %b required 0", err); else passes++;
    endtask

    task automatic test_partial;
        int hs0, rd0, d0, rp;
        push_words(16);
        hs0 = hs_n; rd0 = rd_n; d0 = done_n; rp = rd_ptr;
        start_burst(5'd4);
        wait_done(d0);
        checks++; if (rd_n - rd0 != 4) $display("FAIL part_reads: got %0d required 4", rd_n - rd0); else passes++;
        checks++; if (wr_ptr - rd_ptr != 12) $display("FAIL part_left: got %0d required 12", wr_ptr - rd_ptr); else passes++;
        checks++; if (hs_n - hs0 != 4) $display("FAIL part_count: got %0d required 4", hs_n - hs0); else passes++;
        check_data("part_order", hs0, rp, 4);
        checks++; if (done_cyc <= hs_cyc[hs0 + 3] || done_cyc > hs_cyc[hs0 + 3] + 2)
            $display("FAIL part_done_time: got %0d required %0d..%0d", done_cyc, hs_cyc[hs0 + 3] + 1, hs_cyc[hs0 + 3] + 2);
        else passes++;
    endtask

    task automatic test_error_len0;
        int rd0, d0;
        @(posedge clk); #1;
        rd_error = 1'b1;
        @(posedge clk); #1;
        rd_error = 1'b0;
        checks++; if (err !== 1'b1) $display("FAIL err_set: got %b required 1", err); else passes++;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (err !== 1'b1) $display("FAIL err_sticky: got %b required 1", err); else passes++;
        rd0 = rd_n; d0 = done_n;
        start_burst(5'd0);
        checks++; if (done !== 1'b1) $display("FAIL len0_done: got %b required 1", done); else passes++;
        checks++; if (err !== 1'b0) $display("FAIL len0_err_clear: got %b required 0", err); else passes++;
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) $display("FAIL len0_done_once: got %b required 0", done); else passes++;
        checks++; if (rd_n - rd0 != 0) $display("FAIL len0_reads: got %0d required 0", rd_n - rd0); else passes++;
    endtask

    task automatic test_reset_mid;
        int hs0, d0, rp, left;
        hs0 = hs_n;
        start_burst(5'd8);
        wait_hs(hs0 + 2);
        rd_error = 1'b1;
        @(posedge clk); #1;
        rd_error = 1'b0;
        checks++; if (err !== 1'b1) $display("FAIL mid_err: got %b required 1", err); else passes++;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, rd_en, m_valid, err} !== 5'b0 || m_data !== 8'd0 || rd_count !== 5'd0)
            $display("FAIL mid_reset_outs: got busy=%b done=%b rd=%b v=%b err=%b data=%0d cnt=%0d required all 0",
                     busy, done, rd_en, m_valid, err, m_data, rd_count);
        else passes++;
        start = 1'b1; burst_len = 5'd3;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) $display("FAIL mid_start_in_reset: got %b required 0", busy); else passes++;
        hs0 = hs_n; d0 = done_n; rp = rd_ptr; left = wr_ptr - rd_ptr;
        start_burst(5'(left));
        wait_done(d0);
        checks++; if (hs_n - hs0 != left) $display("FAIL mid_after_count: got %0d required %0d", hs_n - hs0, left); else passes++;
        check_data("mid_after_order", hs0, rp, left);
        checks++; if (rd_count !== 5'(left)) $display("FAIL mid_after_rd_count: got %0d required %0d", rd_count, left); else passes++;
    endtask

    initial begin
        m_ready = 1'b1;
        rd_error = 1'b0;
        rdata = 8'd0;
        test_reset;
        test_full_burst;
        test_backpressure;
        test_underrun;
        test_partial;
        test_error_len0;
        test_reset_mid;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/sync_fifo_drain.md
SYNC_FIFO_DRAIN -- requirements
Module: sync_fifo_drain

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, meaning data word width in bits.
REQ-002 The module SHALL have parameter DEPTH, default 16, meaning the maximum burst length in words, equal to the attached FIFO depth.
REQ-003 The module SHALL have parameter PTR_WIDTH, default 4, meaning log2(DEPTH).
REQ-004 The module SHALL use one clock and an asynchronous, active-high reset: clk_i  input  1  clock, all logic on rising edge.
REQ-005 rst_i  input  1  asynchronous active-high reset.
REQ-006 start_i  input  1  single-cycle burst request, sampled only in IDLE.
REQ-007 burst_len_i  input  PTR_WIDTH+1  number of words to drain, 0..DEPTH, sampled with start_i.
REQ-008 busy_o  output  1  high whenever the state is not IDLE.
REQ-009 done_o  output  1  one-cycle pulse at burst completion.
REQ-010 fifo_rd_en_o  output  1  read strobe to the FIFO read port.
REQ-011 fifo_rdata_i  input  WIDTH  FIFO read data, valid in the cycle after an accepted fifo_rd_en_o.
REQ-012 fifo_empty_i  input  1  FIFO empty flag.
REQ-013 fifo_rd_error_i  input  1  FIFO read-underflow flag.
REQ-014 m_valid_o  output  1  output word valid.
REQ-015 m_data_o  output  WIDTH  output word.
REQ-016 m_ready_i  input  1  downstream ready.
REQ-017 rd_count_o  output  PTR_WIDTH+1  words delivered on the m_ interface in the current burst.
REQ-018 err_o  output  1  sticky underflow error.

Function
REQ-019 The FSM SHALL have the states IDLE, DRAIN, FLUSH and DONE.
REQ-020 In IDLE, start_i=1 with burst_len_i>0 SHALL latch len, clear rd_count_o and err_o, and move to DRAIN; start_i=1 with burst_len_i=0 SHALL go to DONE.
REQ-021 start_i SHALL be ignored outside IDLE.
REQ-022 The module SHALL hold a 2-entry output buffer with an in-flight flag; credit = occupancy + inflight - (m_valid_o & m_ready_i).
REQ-023 fifo_rd_en_o SHALL be asserted combinationally only in DRAIN, when fifo_empty_i=0, issued<len and credit<2.
REQ-024 It SHALL never be asserted when fifo_empty_i=1.
REQ-025 Each asserted fifo_rd_en_o SHALL increment issued and set inflight; on the following edge fifo_rdata_i SHALL be written to the buffer tail.
REQ-026 Latency: a word read at edge E SHALL appear on m_data_o with m_valid_o=1 after edge E+1.
REQ-027 Ordering SHALL be preserved.
REQ-028 With m_ready_i held 1 and the FIFO non-empty, the module SHALL sustain 1 word per cycle.
REQ-029 m_valid_o SHALL be occupancy>0, and m_data_o SHALL be the buffer head.
REQ-030 Once asserted, m_valid_o and m_data_o SHALL stay stable until m_ready_i=1.
REQ-031 rd_count_o SHALL increment on each m_valid_o&m_ready_i and saturate at len.
REQ-032 DRAIN SHALL go to FLUSH when issued==len; FLUSH SHALL go to DONE when occupancy=0 and inflight=0.
REQ-033 DONE SHALL assert done_o for exactly one cycle, then go to IDLE.
REQ-034 If the FIFO empties mid-burst, DRAIN SHALL wait with rd_en low and resume when fifo_empty_i=0; there is no timeout.
REQ-035 fifo_rd_error_i=1 on any edge SHALL set err_o.
REQ-036 err_o SHALL clear only on reset or on an accepted start_i; the word count SHALL be unaffected.

Reset
REQ-037 rst_i=1 SHALL immediately force: state IDLE, busy_o=0, done_o=0, fifo_rd_en_o=0, m_valid_o=0, m_data_o=0, rd_count_o=0, err_o=0, occupancy=0, inflight=0, issued=0.
REQ-038 A reset mid-burst SHALL discard buffered and in-flight words.
REQ-039 No start_i SHALL be accepted while rst_i=1.

Verification
REQ-040 FIFO preloaded with 16 words, start with len=16, m_ready_i=1 -> 16 words in write order, first m_valid_o 2 edges after fifo_rd_en_o, 1 word/cycle, done_o pulses once, rd_count_o=16, err_o=0.
REQ-041 len=4 with 16 words stored -> exactly 4 reads issued, 12 words remain in FIFO, done_o pulses after the 4th handshake.
REQ-042 m_ready_i low for 5 cycles mid-burst -> at most 2 buffered words, fifo_rd_en_o low while credit=2, m_data_o stable, no loss or duplication.
REQ-043 len=8 with only 3 words stored, then 5 more written 10 cycles later -> fifo_rd_en_o never high while empty, all 8 delivered, err_o=0.
REQ-044 Force fifo_rd_error_i=1 for one cycle -> err_o=1 until the next accepted start_i; start_i with len=0 -> done_o pulse 1 cycle later, no reads.
REQ-045 Assert rst_i asynchronously between edges mid-burst -> all outputs 0 immediately; a new burst after release drains correctly.
